// File: rtl/bt_frame_responder.sv
// Bluetooth UART frame receiver: collects FRAME_BYTES bytes into one command word
// and answers every frame with ACK_MSG, or NAK_MSG when a stop bit is bad.
module bt_frame_responder #(
  parameter int                   CLKS_PER_BIT = 5208,
  parameter int                   FRAME_BYTES  = 4,
  parameter int                   MSG_LEN      = 8,
  parameter logic [8*MSG_LEN-1:0] ACK_MSG      = 64'h5375636365737321,
  parameter logic [8*MSG_LEN-1:0] NAK_MSG      = 64'h4661696C75726521,
  parameter int                   TIMEOUT_CLKS = 20*5208
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bt_rxd,
  output logic                     bt_txd,
  output logic [8*FRAME_BYTES-1:0] recv_data,
  output logic                     recv_valid,
  output logic                     frame_err,
  output logic                     frame_timeout,
  output logic                     tx_busy,
  output logic                     tx_overrun,
  output logic [1:0]               rx_state_dbg,
  output logic [2:0]               tx_state_dbg
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam int MW = $clog2(MSG_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int FW = 8 * FRAME_BYTES;
  localparam int SW = 8 * MSG_LEN;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] FULL      = BW'(FRAME_BYTES);
  localparam logic [MW-1:0] MSG_LAST  = MW'(MSG_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_NEXT} tx_state_t;

  // Handshake: ack_req/nak_req are single-cycle requests; TX takes a request only
  // while in TX_IDLE, otherwise it is dropped and tx_overrun pulses.
  logic            rx_meta_q, rx_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_brk_q, rx_brk_d;
  logic [FW-1:0]   shift_q, shift_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [FW-1:0]   recv_data_q, recv_data_d;
  logic            recv_valid_q, recv_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            frame_timeout_q, frame_timeout_d;
  logic            ack_req, nak_req, tx_req;

  tx_state_t       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [MW-1:0]   tx_idx_q, tx_idx_d;
  logic [SW-1:0]   tx_shift_q, tx_shift_d;
  logic [7:0]      tx_byte;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;

  always_comb begin
    rx_state_d      = rx_state_q;
    rx_cnt_d        = rx_cnt_q;
    rx_bit_d        = rx_bit_q;
    rx_byte_d       = rx_byte_q;
    rx_brk_d        = rx_brk_q;
    shift_d         = shift_q;
    byte_cnt_d      = byte_cnt_q;
    to_cnt_d        = to_cnt_q;
    recv_data_d     = recv_data_q;
    recv_valid_d    = 1'b0;
    frame_err_d     = 1'b0;
    frame_timeout_d = 1'b0;
    ack_req         = 1'b0;
    nak_req         = 1'b0;

    if (byte_cnt_q == FULL) begin
      recv_data_d  = shift_q;
      recv_valid_d = 1'b1;
      byte_cnt_d   = '0;
      ack_req      = 1'b1;
    end

    unique case (rx_state_q)
      RX_IDLE: if (!rx_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = rx_q ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d  = '0;
        rx_byte_d = {rx_q, rx_byte_q[7:1]};
        rx_bit_d  = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_STOP: if (rx_brk_q) begin
        // After a bad stop bit the line may stay low; hold off until it idles.
        if (rx_q) begin
          rx_brk_d   = 1'b0;
          rx_state_d = RX_IDLE;
        end
      end else if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        if (rx_q) begin
          shift_d    = (shift_q << 8) | FW'(rx_byte_q);
          byte_cnt_d = byte_cnt_q + 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          byte_cnt_d  = '0;
          frame_err_d = 1'b1;
          nak_req     = 1'b1;
          rx_brk_d    = 1'b1;
        end
      end else rx_cnt_d = rx_cnt_q + 1'b1;
    endcase

    if (rx_state_q == RX_IDLE && byte_cnt_q != '0 && byte_cnt_q != FULL) begin
      if (!rx_q) to_cnt_d = '0;
      else if (to_cnt_q >= TO_LAST) begin
        to_cnt_d        = '0;
        byte_cnt_d      = '0;
        frame_timeout_d = 1'b1;
      end else to_cnt_d = to_cnt_q + 1'b1;
    end else if (byte_cnt_q == '0) begin
      to_cnt_d = '0;
    end
  end

  assign tx_req = ack_req | nak_req;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    ovr_d      = tx_req && (tx_state_q != TX_IDLE);

    unique case (tx_state_q)
      TX_IDLE: if (tx_req) begin
        tx_shift_d = ack_req ? ACK_MSG : NAK_MSG;
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      // The stop bit is STOP (CLKS_PER_BIT-1 cycles) plus the one NEXT cycle.
      TX_STOP: if (tx_cnt_q == STOP_LAST) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_NEXT;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      TX_NEXT: if (tx_idx_q == MSG_LAST) begin
        tx_state_d = TX_IDLE;
      end else begin
        tx_idx_d   = tx_idx_q + 1'b1;
        tx_shift_d = tx_shift_q << 8;
        tx_state_d = TX_START;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    tx_byte = tx_shift_d[SW-1 -: 8];
    unique case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_byte[tx_bit_d];
      default:  txd_d = 1'b1;
    endcase
    busy_d = (tx_state_d != TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q       <= 1'b1;
      rx_q            <= 1'b1;
      rx_state_q      <= RX_IDLE;
      rx_cnt_q        <= '0;
      rx_bit_q        <= '0;
      rx_byte_q       <= '0;
      rx_brk_q        <= 1'b0;
      shift_q         <= '0;
      byte_cnt_q      <= '0;
      to_cnt_q        <= '0;
      recv_data_q     <= '0;
      recv_valid_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      frame_timeout_q <= 1'b0;
      tx_state_q      <= TX_IDLE;
      tx_cnt_q        <= '0;
      tx_bit_q        <= '0;
      tx_idx_q        <= '0;
      tx_shift_q      <= '0;
      txd_q           <= 1'b1;
      busy_q          <= 1'b0;
      ovr_q           <= 1'b0;
    end else begin
      rx_meta_q       <= bt_rxd;
      rx_q            <= rx_meta_q;
      rx_state_q      <= rx_state_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_bit_q        <= rx_bit_d;
      rx_byte_q       <= rx_byte_d;
      rx_brk_q        <= rx_brk_d;
      shift_q         <= shift_d;
      byte_cnt_q      <= byte_cnt_d;
      to_cnt_q        <= to_cnt_d;
      recv_data_q     <= recv_data_d;
      recv_valid_q    <= recv_valid_d;
      frame_err_q     <= frame_err_d;
      frame_timeout_q <= frame_timeout_d;
      tx_state_q      <= tx_state_d;
      tx_cnt_q        <= tx_cnt_d;
      tx_bit_q        <= tx_bit_d;
      tx_idx_q        <= tx_idx_d;
      tx_shift_q      <= tx_shift_d;
      txd_q           <= txd_d;
      busy_q          <= busy_d;
      ovr_q           <= ovr_d;
    end
  end

  assign bt_txd        = txd_q;
  assign recv_data     = recv_data_q;
  assign recv_valid    = recv_valid_q;
  assign frame_err     = frame_err_q;
  assign frame_timeout = frame_timeout_q;
  assign tx_busy       = busy_q;
  assign tx_overrun    = ovr_q;
  assign rx_state_dbg  = rx_state_q;
  assign tx_state_dbg  = tx_state_q;
endmodule

// File: tb/tb_bt_frame_responder.sv
// Bench for bt_frame_responder: table of frames driven on bt_rxd, responses decoded
// from bt_txd and compared against an expected byte queue.
module tb_bt_frame_responder;
  localparam int CPB = 4;
  localparam int FB  = 4;
  localparam int ML  = 8;
  localparam int TO  = 20 * CPB;
  localparam logic [63:0] ACK = 64'h5375636365737321;
  localparam logic [63:0] NAK = 64'h4661696C75726521;
  localparam int NV  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bt_rxd = 1'b1;
  logic        bt_txd;
  logic [31:0] recv_data;
  logic        recv_valid, frame_err, frame_timeout, tx_busy, tx_overrun;
  logic [1:0]  rx_state_dbg;
  logic [2:0]  tx_state_dbg;

  int total = 0, bad = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_data_q[$];
  int n_valid = 0, n_err = 0, n_to = 0, n_ovr = 0, mon_bytes = 0;
  int e_valid = 0, e_err = 0, e_to = 0, e_ovr = 0;
  logic [31:0] last_data = '0;

  typedef struct {
    logic [31:0] bytes;
    int          n_bytes;
    int          bad_idx;
    int          idle_after;
    bit          wait_tx;
    bit          exp_valid;
    logic [31:0] exp_data;
    int          exp_resp;
    int          exp_err;
    int          exp_to;
    int          exp_ovr;
  } vec_t;

  bt_frame_responder #(
    .CLKS_PER_BIT(CPB), .FRAME_BYTES(FB), .MSG_LEN(ML),
    .ACK_MSG(ACK), .NAK_MSG(NAK), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk), .rst(rst), .bt_rxd(bt_rxd), .bt_txd(bt_txd),
    .recv_data(recv_data), .recv_valid(recv_valid), .frame_err(frame_err),
    .frame_timeout(frame_timeout), .tx_busy(tx_busy), .tx_overrun(tx_overrun),
    .rx_state_dbg(rx_state_dbg), .tx_state_dbg(tx_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok);
    bt_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bt_rxd = d[i];
      tick(CPB);
    end
    bt_rxd = stop_ok;
    tick(CPB);
    if (!stop_ok) begin
      bt_rxd = 1'b1;
      tick(2 * CPB);
    end
  endtask

  task automatic push_msg(input logic [63:0] m);
    for (int i = ML - 1; i >= 0; i--) exp_q.push_back(m[i*8 +: 8]);
  endtask

  task automatic wait_tx_idle();
    int w = 0;
    while ((tx_busy !== 1'b0 || exp_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("tx_drain_in_time", 32'(w < 3000), 32'd1);
    tick(4);
  endtask

  // scoreboard: decode bt_txd bytes and pop expected queue
  initial begin : tx_mon
    int cnt;
    bit act;
    logic [7:0] b;
    cnt = 0; act = 1'b0; b = '0;
    forever begin
      @(negedge clk);
      if (rst) act = 1'b0;
      else if (!act) begin
        if (bt_txd === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == CPB / 2) check("tx_start_bit", 32'(bt_txd), 32'd0);
        else if (cnt >= CPB + CPB / 2 && cnt <= 8 * CPB + CPB / 2 && (cnt % CPB) == CPB / 2)
          b = {bt_txd, b[7:1]};
        else if (cnt == 9 * CPB + CPB / 2) begin
          check("tx_stop_bit", 32'(bt_txd), 32'd1);
          act = 1'b0;
          mon_bytes++;
          check("tx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("tx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : busy_mon
    int len;
    len = 0;
    forever begin
      @(negedge clk);
      if (rst) len = 0;
      else if (tx_busy === 1'b1) len++;
      else if (len != 0) begin
        check("tx_busy_len", 32'(len), 32'(ML * 10 * CPB));
        len = 0;
      end
    end
  end

  initial begin : pulse_mon
    bit pv, pe, pt, po;
    pv = 0; pe = 0; pt = 0; po = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (recv_valid === 1'b1) begin
          n_valid++;
          check("recv_valid_width", 32'(pv), 32'd0);
          check("recv_valid_expected", 32'(exp_data_q.size() != 0), 32'd1);
          if (exp_data_q.size() != 0) check("recv_data", recv_data, exp_data_q.pop_front());
        end
        if (frame_err === 1'b1) begin
          n_err++;
          check("frame_err_width", 32'(pe), 32'd0);
        end
        if (frame_timeout === 1'b1) begin
          n_to++;
          check("frame_timeout_width", 32'(pt), 32'd0);
        end
        if (tx_overrun === 1'b1) begin
          n_ovr++;
          check("tx_overrun_width", 32'(po), 32'd0);
        end
      end
      pv = (recv_valid === 1'b1);
      pe = (frame_err === 1'b1);
      pt = (frame_timeout === 1'b1);
      po = (tx_overrun === 1'b1);
    end
  end

  initial begin : main
    vec_t vecs[NV];
    logic [31:0] r;
    int base, w;

    r = $urandom();
    vecs[0] = '{32'h12345678, 4, -1, 8,      1'b1, 1'b1, 32'h12345678, 1, 0, 0, 0};
    vecs[1] = '{32'h9A5C0000, 2,  1, 8,      1'b1, 1'b0, 32'h0,        2, 1, 0, 0};
    vecs[2] = '{32'h0F1E2D3C, 4, -1, 8,      1'b1, 1'b1, 32'h0F1E2D3C, 1, 0, 0, 0};
    vecs[3] = '{32'h55660000, 2, -1, TO + 10, 1'b1, 1'b0, 32'h0,       0, 0, 1, 0};
    vecs[4] = '{32'hAABBCCDD, 4, -1, 8,      1'b1, 1'b1, 32'hAABBCCDD, 1, 0, 0, 0};
    vecs[5] = '{32'hDEADBEEF, 4, -1, 8,      1'b0, 1'b1, 32'hDEADBEEF, 1, 0, 0, 0};
    vecs[6] = '{32'h01020304, 4, -1, 8,      1'b1, 1'b1, 32'h01020304, 0, 0, 0, 1};
    vecs[7] = '{r, 4, -1, $urandom_range(8, 30), 1'b1, 1'b1, r,         1, 0, 0, 0};

    rst = 1'b1;
    bt_rxd = 1'b1;
    tick(3);
    check("rst_bt_txd", 32'(bt_txd), 32'd1);
    check("rst_recv_data", recv_data, 32'h0);
    check("rst_recv_valid", 32'(recv_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_frame_timeout", 32'(frame_timeout), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_overrun", 32'(tx_overrun), 32'd0);
    rst = 1'b0;
    tick(200);
    check("idle_bt_txd", 32'(bt_txd), 32'd1);
    check("idle_tx_busy", 32'(tx_busy), 32'd0);
    check("idle_pulses", 32'(n_valid + n_err + n_to + n_ovr + mon_bytes), 32'd0);

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].exp_resp == 1) push_msg(ACK);
      else if (vecs[v].exp_resp == 2) push_msg(NAK);
      if (vecs[v].exp_valid) begin
        exp_data_q.push_back(vecs[v].exp_data);
        e_valid++;
        last_data = vecs[v].exp_data;
      end
      e_err += vecs[v].exp_err;
      e_to  += vecs[v].exp_to;
      e_ovr += vecs[v].exp_ovr;
      for (int i = 0; i < vecs[v].n_bytes; i++)
        send_byte(vecs[v].bytes[31 - 8*i -: 8], i != vecs[v].bad_idx);
      tick(vecs[v].idle_after);
      if (vecs[v].wait_tx) wait_tx_idle();
      check($sformatf("v%0d_recv_valid_count", v), 32'(n_valid), 32'(e_valid));
      check($sformatf("v%0d_frame_err_count", v), 32'(n_err), 32'(e_err));
      check($sformatf("v%0d_frame_timeout_count", v), 32'(n_to), 32'(e_to));
      check($sformatf("v%0d_tx_overrun_count", v), 32'(n_ovr), 32'(e_ovr));
      check($sformatf("v%0d_recv_data_held", v), recv_data, last_data);
    end

    // one-cycle glitch, then a frame that must still assemble from exactly 4 bytes
    bt_rxd = 1'b0;
    tick(1);
    bt_rxd = 1'b1;
    tick(20);
    base = mon_bytes;
    push_msg(ACK);
    exp_data_q.push_back(32'h13579BDF);
    e_valid++;
    last_data = 32'h13579BDF;
    for (int i = 0; i < 4; i++) begin
      r = 32'h13579BDF;
      send_byte(r[31 - 8*i -: 8], 1'b1);
    end
    tick(8);
    check("glitch_recv_valid_count", 32'(n_valid), 32'(e_valid));
    check("glitch_recv_data", recv_data, last_data);

    // reset in the middle of the third ACK byte
    w = 0;
    while (mon_bytes < base + 2 && w < 2000) begin
      tick(1);
      w++;
    end
    check("ack_byte2_in_time", 32'(w < 2000), 32'd1);
    tick(10);
    check("mid_ack_busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_bt_txd", 32'(bt_txd), 32'd1);
    check("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_recv_data", recv_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    last_data = '0;
    tick(500);
    check("post_rst_no_bytes", 32'(mon_bytes), 32'(base + 2));
    check("post_rst_bt_txd", 32'(bt_txd), 32'd1);
    check("post_rst_pulses", 32'(n_err + n_to + n_ovr), 32'(e_err + e_to + e_ovr));

    check("tx_queue_empty", 32'(exp_q.size()), 32'd0);
    check("data_queue_empty", 32'(exp_data_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bt_frame_responder.md
Name: bt_frame_responder

Overview:
- Self-contained UART frame receiver with automatic acknowledge.
- Assembles FRAME_BYTES serial bytes from the Bluetooth module into one data word, then returns ACK_MSG on success or NAK_MSG on a framing error.
- Drops partial frames after an inter-byte timeout.
- Sits between the Bluetooth UART pins and the DDS control registers; parameter/command words enter the design through this block.

Parameters:
- CLKS_PER_BIT, 5208: clk cycles per UART bit (50 MHz / 9600 baud); minimum 4.
- FRAME_BYTES, 4: payload bytes per frame, range 1..8.
- MSG_LEN, 8: bytes in each response message, range 1..16.
- ACK_MSG, 64'h5375636365737321: success response, ASCII "Success!"; first transmitted byte at MSB; width 8*MSG_LEN.
- NAK_MSG, 64'h4661696C75726521: error response, ASCII "Failure!"; same layout and width as ACK_MSG.
- TIMEOUT_CLKS, 20*5208: idle cycles after a stop bit before a partial frame is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bt_rxd  in  1  UART receive line, asynchronous, idle high
- bt_txd  out  1  UART transmit line, idle high
- recv_data  out  8*FRAME_BYTES  last good frame; first received byte at MSB
- recv_valid  out  1  one-cycle pulse when recv_data updates
- frame_err  out  1  one-cycle pulse on a stop-bit error
- frame_timeout  out  1  one-cycle pulse when a partial frame is discarded
- tx_busy  out  1  high while a response is being shifted out
- tx_overrun  out  1  one-cycle pulse when a response request is dropped

Behaviour:
- Reset (rst sampled high on a clk edge):
  - Outputs: bt_txd=1, recv_data=0, recv_valid=0, frame_err=0, frame_timeout=0, tx_busy=0, tx_overrun=0.
  - Both FSMs go to IDLE; byte count and timeout counter clear to 0.
  - Reset mid-byte or mid-response aborts immediately, with no pulses.
- Input sync: bt_rxd passes through a 2-flop synchronizer; "rx" below means the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx low moves to START, bit counter cleared.
  - START: at CLKS_PER_BIT/2, rx still low moves to DATA. rx high is a glitch: return to IDLE, no pulse.
  - DATA: sample every CLKS_PER_BIT, LSB first, 8 bits.
  - STOP: sample once after CLKS_PER_BIT.
    - rx=1: byte accepted into a shift register (previous content shifts left 8), byte count +1.
    - rx=0: framing error. Discard the partial frame, count=0, pulse frame_err, request NAK. Then wait for rx high before IDLE.
- Frame complete: the accepted byte makes count == FRAME_BYTES.
  - On the next cycle: recv_data loads, recv_valid pulses, count=0, ACK requested.
- Timeout: runs only while 0 < count < FRAME_BYTES and the RX FSM is in IDLE; cleared on each start edge.
  - On reaching TIMEOUT_CLKS: count=0, frame_timeout pulses, no response sent, recv_data unchanged.
- TX FSM states: IDLE, START, DATA, STOP, NEXT.
  - A request arriving while in IDLE loads the chosen message into a shift register.
  - tx_busy and the start bit (bt_txd=0) begin on the cycle after the request.
  - Each byte is sent as 1 start bit, 8 data bits LSB first, 1 stop bit; every bit lasts CLKS_PER_BIT cycles.
  - Bytes are sent MSB byte first, back-to-back with no extra idle.
  - tx_busy falls on the cycle after the last stop bit completes.
- Overrun: a request arriving while tx_busy is high is dropped and tx_overrun pulses. The current message continues unaffected.
- Duplex: RX runs fully independently of TX.
- Simultaneous events: ACK and NAK requests cannot coincide (one stop bit per cycle). A request on the same cycle tx_busy falls is accepted, not dropped.
- Width rules:
  - Bit-timing counters: $clog2(CLKS_PER_BIT) bits.
  - Timeout counter saturates at TIMEOUT_CLKS.
  - Byte counters: $clog2 of range + 1 bits.

Test Plan:
- Reset and idle: with CLKS_PER_BIT=4, FRAME_BYTES=4, assert rst for 3 cycles -> bt_txd=1, recv_data=0, all pulses 0; rx held high for 200 cycles -> no activity.
- Good frame: send 0x12,0x34,0x56,0x78 -> recv_data=32'h12345678, recv_valid exactly 1 cycle. bt_txd then carries 8 bytes 0x53 0x75 0x63 0x63 0x65 0x73 0x73 0x21, each 40 cycles; tx_busy high 320 cycles.
- Framing error: second byte sent with stop bit 0 -> frame_err pulse, recv_data unchanged, NAK bytes 0x46 0x61 0x69 0x6C 0x75 0x72 0x65 0x21 transmitted. The next 4 good bytes give a correct frame.
- Timeout: send 2 bytes, then idle for TIMEOUT_CLKS+10 -> frame_timeout pulse, no tx. The following 4 bytes 0xAA,0xBB,0xCC,0xDD -> recv_data=32'hAABBCCDD.
- Overrun: send a second full frame while the first ACK is still transmitting -> recv_valid pulses, tx_overrun pulses, exactly one ACK (8 bytes) on bt_txd.
- Glitch and mid-op reset: a 1-cycle low on bt_rxd -> no byte counted. rst asserted during ACK byte 3 -> bt_txd=1 and tx_busy=0 on the next cycle, no further bytes.
